// File: rtl/disp_pkg.sv
// Shared constants for the front-panel 7-segment display path.
// Holds the nibble width, the inactive levels of the active-low anode and
// decimal-point lines, and a constant-evaluable log2 helper for sizing
// counters. Used by the scanner, the segment decoder and the display wrapper.
package disp_pkg;

    localparam int   DIGIT_W = 4;
    localparam logic AN_OFF  = 1'b1;
    localparam logic DP_OFF  = 1'b1;

    // Bits needed to hold 0..n-1. Returns at least 1 so a single-digit
    // build still gets a legal one-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lz_blank_mask.sv
// Leading-zero blank mask.
// Walks the digits from the most significant one downward. A digit is
// blanked while every nibble from it up to the top is zero and none of
// those digits asks for its decimal point. Digit 0 is never blanked, so an
// all-zero value still shows a single "0".
// Ports:
//   i_value  packed nibbles, nibble i = i_value[4i+3:4i]
//   i_dp     decimal-point request per digit
//   o_blank  1 = digit is dark for its whole slot
module lz_blank_mask
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic [DIGIT_W*DIGITS-1:0] i_value,
    input  logic [DIGITS-1:0]         i_dp,
    output logic [DIGITS-1:0]         o_blank
);

    logic w_lead;

    // Scan MSD -> digit 1; w_lead stays high while still inside the leading zeros.
    always_comb begin
        o_blank = '0;
        w_lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if ((i_value[i*DIGIT_W +: DIGIT_W] != 4'h0) || i_dp[i]) begin
                w_lead = 1'b0;
            end else begin
                w_lead = w_lead;
            end
            o_blank[i] = w_lead & BLANK_LZ;
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Latches a packed measurement word on load and steps through the digits,
// one slot of REFRESH_DIV cycles each. The first GUARD cycles of a slot keep
// every anode off so the previous digit cannot ghost into the next one.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (wins over load)
//   value  packed nibbles, nibble i = value[4i+3:4i], digit 0 = LSD
//   dp_in  decimal-point request per digit, 1 = lit
//   load   capture value/dp_in on this edge
//   code   nibble of the current digit, to the segment decoder
//   an     active-low digit anodes, at most one low
//   dp     active-low decimal point
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGIT_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      load,
    output logic [DIGIT_W-1:0]        code,
    output logic [DIGITS-1:0]         an,
    output logic                      dp
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int PRE_W = clog2(REFRESH_DIV);

    if ((DIGITS < 1) || (DIGITS > 8) || (REFRESH_DIV < GUARD + 2)) begin : g_param_check
        $error("display_scan_mux: illegal DIGITS/REFRESH_DIV/GUARD combination");
    end

    logic [DIGIT_W*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]         r_dp_sh;
    logic [PRE_W-1:0]          r_pre;
    logic [IDX_W-1:0]          r_idx;
    logic [DIGIT_W-1:0]        r_code;
    logic [DIGITS-1:0]         r_an;
    logic                      r_dp;

    logic [DIGITS-1:0]         w_blank;
    logic [DIGIT_W*DIGITS-1:0] w_nib_shift;
    logic [DIGITS-1:0]         w_dp_shift;
    logic [DIGITS-1:0]         w_blank_shift;
    logic [DIGIT_W-1:0]        w_code_nx;
    logic [DIGITS-1:0]         w_an_nx;
    logic                      w_dp_nx;

    lz_blank_mask #(
        .DIGITS   (DIGITS),
        .BLANK_LZ (BLANK_LZ)
    ) u_lz_blank_mask (
        .i_value (r_value),
        .i_dp    (r_dp_sh),
        .o_blank (w_blank)
    );

    // Next output values from the current slot position and shadow contents.
    always_comb begin
        // Nibble select: idx*4 is formed by appending two zero bits.
        w_nib_shift   = r_value >> {r_idx, 2'b00};
        w_dp_shift    = r_dp_sh >> r_idx;
        w_blank_shift = w_blank >> r_idx;
        w_code_nx     = w_nib_shift[DIGIT_W-1:0];
        w_an_nx       = {DIGITS{AN_OFF}};
        w_dp_nx       = DP_OFF;
        if ((r_pre < PRE_W'(GUARD)) || w_blank_shift[0]) begin
            w_an_nx = {DIGITS{AN_OFF}};
            w_dp_nx = DP_OFF;
        end else begin
            w_an_nx = ~(DIGITS'(1) << r_idx);
            w_dp_nx = ~w_dp_shift[0];
        end
    end

    // Shadow capture, prescaler/digit index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_dp_sh <= '0;
            r_pre   <= '0;
            r_idx   <= '0;
            r_code  <= 4'h0;
            r_an    <= {DIGITS{AN_OFF}};
            r_dp    <= DP_OFF;
        end else begin
            if (load) begin
                r_value <= value;
                r_dp_sh <= dp_in;
            end else begin
                r_value <= r_value;
                r_dp_sh <= r_dp_sh;
            end
            if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
                r_idx <= r_idx;
            end
            r_code <= w_code_nx;
            r_an   <= w_an_nx;
            r_dp   <= w_dp_nx;
        end
    end

    assign code = r_code;
    assign an   = r_an;
    assign dp   = r_dp;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux. Two instances share the stimulus:
// one with leading-zero blanking, one without. A reference model tracks
// elapsed cycles since reset and the latched digits, derives slot/phase by
// division, and queues the expected outputs; a monitor pops and compares.
module tb_display_scan_mux;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int G  = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;

    logic [3:0] code_a, an_a, code_b, an_b;
    logic       dp_a, dp_b;

    display_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .code(code_a), .an(an_a), .dp(dp_a)
    );

    display_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(G), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .code(code_b), .an(an_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code_a;
        logic [3:0] an_a;
        logic       dp_a;
        logic [3:0] code_b;
        logic [3:0] an_b;
        logic       dp_b;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: cycles since reset and the latched display word.
    int         t = 0;
    logic [3:0] m_nib[D];
    logic       m_dp[D];

    // What the display should show at cycle t of the scan.
    function automatic void model_out(input bit blz, output logic [3:0] c,
                                      output logic [3:0] a, output logic d);
        int idx, ph, top;
        idx = (t / RD) % D;
        ph  = t % RD;
        top = -1;
        for (int i = 0; i < D; i++) begin
            if (m_nib[i] != 4'h0 || m_dp[i]) top = i;
        end
        c = m_nib[idx];
        a = 4'hF;
        d = 1'b1;
        if (ph >= G && !(blz && idx > 0 && idx > top)) begin
            a[idx] = 1'b0;
            d      = ~m_dp[idx];
        end
    endfunction

    // Model: at each edge predict the registered outputs, then advance.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                e = '{4'h0, 4'hF, 1'b1, 4'h0, 4'hF, 1'b1};
                t = 0;
                for (int i = 0; i < D; i++) begin
                    m_nib[i] = 4'h0;
                    m_dp[i]  = 1'b0;
                end
            end else begin
                model_out(1'b1, e.code_a, e.an_a, e.dp_a);
                model_out(1'b0, e.code_b, e.an_b, e.dp_b);
                t = t + 1;
                if (load) begin
                    for (int i = 0; i < D; i++) begin
                        m_nib[i] = value[i*4 +: 4];
                        m_dp[i]  = dp_in[i];
                    end
                end
            end
            q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("code_lz", {4'h0, code_a}, {4'h0, e.code_a});
                chk("an_lz",   {4'h0, an_a},   {4'h0, e.an_a});
                chk("dp_lz",   {7'h0, dp_a},   {7'h0, e.dp_a});
                chk("code_nb", {4'h0, code_b}, {4'h0, e.code_b});
                chk("an_nb",   {4'h0, an_b},   {4'h0, e.an_b});
                chk("dp_nb",   {7'h0, dp_b},   {7'h0, e.dp_b});
                chk("an_onehot", 8'($countones(~an_a) <= 1 && $countones(~an_b) <= 1), 8'd1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input int hold);
        value = v;
        dp_in = d;
        load  = 1'b1;
        cyc(hold);
        load  = 1'b0;
    endtask

    // Wait (bounded) until the next edge is at scan position pos of 0..31.
    task automatic wait_pos(input int pos, input string name);
        for (int k = 0; k < 64 && (t % (RD * D)) != pos; k++) cyc(1);
        chk(name, 8'(t % (RD * D)), 8'(pos));
    endtask

    initial begin
        logic [15:0] v;
        int          k;
        cyc(3);
        rst = 1'b0;
        cyc(40);
        do_load(16'h1A3F, 4'b0000, 1);
        cyc(70);
        do_load(16'h0042, 4'b0000, 1);
        cyc(40);
        do_load(16'h0005, 4'b0100, 1);
        cyc(40);
        // Load on the edge where slot 3 wraps to slot 0.
        wait_pos(RD * D - 1, "wrap_align");
        do_load(16'h9999, 4'b0000, 1);
        cyc(40);
        // Reset during the ON phase of digit 2.
        wait_pos(2 * RD + 4, "midslot_align");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(40);
        repeat (25) begin
            v = 16'($urandom);
            k = $urandom_range(0, 4);
            v = v & (16'hFFFF >> (4 * k));
            do_load(v, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                    $urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) begin
                cyc($urandom_range(1, 20));
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc($urandom_range(5, 40));
        end
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
